alu_sequencer: RTL and testbench

- Command-driven controller for the 8-bit ALU datapath (input muxes, operand DFFs, AND/OR/XOR/NOT/ADD/SUB/MULT, one-hot output mux).
- Queues operation commands in a small FIFO and issues them one at a time to the datapath.
- Drives the datapath's in_selector/out_selector/operands, waits the datapath latency, then captures the result.
- Runs the OFF/READY/RUN/RUN_ERROR state machine, with MULT overflow as the error source.

---
 rtl/alu_pkg.sv | 57 +++++
 rtl/cmd_fifo.sv | 62 ++++++
 rtl/alu_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_sequencer.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared encodings for the ALU sequencer slice.
// States, op codes and one-hot datapath selector constants.
package alu_pkg;

  localparam int ALU_WIDTH = 8;

  typedef enum logic [1:0] {
    ST_OFF   = 2'b00,
    ST_READY = 2'b01,
    ST_RUN   = 2'b10,
    ST_ERR   = 2'b11
  } seqState_t;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOT  = 3'd3,
    OP_ADD  = 3'd4,
    OP_SUB  = 3'd5,
    OP_MULT = 3'd6,
    OP_CLR  = 3'd7
  } aluOp_t;

  localparam logic [2:0] IN_PERSIST = 3'b001;
  localparam logic [2:0] IN_LOAD    = 3'b010;
  localparam logic [2:0] IN_RESET   = 3'b100;

  localparam logic [6:0] OUT_AND  = 7'b0000001;
  localparam logic [6:0] OUT_OR   = 7'b0000010;
  localparam logic [6:0] OUT_XOR  = 7'b0000100;
  localparam logic [6:0] OUT_NOT  = 7'b0001000;
  localparam logic [6:0] OUT_ADD  = 7'b0010000;
  localparam logic [6:0] OUT_SUB  = 7'b0100000;
  localparam logic [6:0] OUT_MULT = 7'b1000000;

  // CLR has no output-mux leg of its own; it rides on AND.
  function automatic logic [6:0] opOutSel(input aluOp_t op);
    logic [6:0] sel;
    sel = OUT_AND;
    unique case (op)
      OP_OR:   sel = OUT_OR;
      OP_XOR:  sel = OUT_XOR;
      OP_NOT:  sel = OUT_NOT;
      OP_ADD:  sel = OUT_ADD;
      OP_SUB:  sel = OUT_SUB;
      OP_MULT: sel = OUT_MULT;
      default: sel = OUT_AND;
    endcase
    return sel;
  endfunction

  function automatic logic [2:0] opInSel(input aluOp_t op);
    return (op == OP_CLR) ? IN_RESET : IN_LOAD;
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// cmd_fifo: small command queue for the ALU sequencer.
// Payload is {op, load, a, b}; flush is synchronous.
module cmd_fifo
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic               flush,
  input  logic [2*WIDTH+3:0] wrData,
  output logic [2*WIDTH+3:0] rdData,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [2*WIDTH+3:0] mem [DEPTH];
  logic [AW-1:0] wrPtr;
  logic [AW-1:0] rdPtr;
  logic [AW:0] count;
  logic doPush;
  logic doPop;

  assign full = (count == FULL_CNT);
  assign empty = (count == '0);
  assign doPush = push && !full;
  assign doPop = pop && !empty;
  assign rdData = mem[rdPtr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else if (flush) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush)
        wrPtr <= wrPtr + 1'b1;
      if (doPop)
        rdPtr <= rdPtr + 1'b1;
      if (doPush && !doPop)
        count <= count + 1'b1;
      else if (doPop && !doPush)
        count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (doPush && !flush)
      mem[wrPtr] <= wrData;
  end

endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: queues ALU commands and issues them to the
// 8-bit datapath one at a time, capturing each result.
module alu_sequencer
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_WIDTH,
  parameter int DEPTH = 4,
  parameter int LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             on,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic             cmd_load,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  output logic [2:0]       dp_in_sel,
  output logic [WIDTH-1:0] dp_num1,
  output logic [WIDTH-1:0] dp_num2,
  output logic [6:0]       dp_out_sel,
  input  logic [WIDTH-1:0] dp_result,
  input  logic             dp_overflow,
  output logic             res_valid,
  output logic [WIDTH-1:0] res_data,
  output logic             res_error,
  input  logic             err_ack,
  output logic [1:0]       state,
  output logic [1:0]       next
);

  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(LAT - 1);

  seqState_t stateQ;
  seqState_t stateD;

  logic fifoPush;
  logic fifoPop;
  logic fifoFlush;
  logic fifoFull;
  logic fifoEmpty;
  logic [2*WIDTH+3:0] fifoWr;
  logic [2*WIDTH+3:0] fifoRd;

  logic [2:0] headOpRaw;
  aluOp_t headOp;
  logic headLoad;
  logic [WIDTH-1:0] headA;
  logic [WIDTH-1:0] headB;

  aluOp_t opQ;
  logic [CW-1:0] cntQ;
  logic [2:0] inSelQ;
  logic [WIDTH-1:0] num1Q;
  logic [WIDTH-1:0] num2Q;
  logic [6:0] outSelQ;
  logic [WIDTH-1:0] accQ;
  logic [WIDTH-1:0] resDataQ;
  logic resValidQ;

  logic startOp;
  logic finishOp;
  logic opFault;
  logic [WIDTH-1:0] capture;

  assign fifoWr = {cmd_op, cmd_load, cmd_a, cmd_b};
  assign {headOpRaw, headLoad, headA, headB} = fifoRd;
  assign headOp = aluOp_t'(headOpRaw);

  assign startOp = (stateQ == ST_READY) && on && !fifoEmpty;
  assign finishOp = (stateQ == ST_RUN) && (cntQ == '0);
  assign opFault = finishOp && (opQ == OP_MULT) && dp_overflow;
  assign capture = (opQ == OP_CLR) ? '0 : dp_result;

  assign fifoPush = cmd_valid && cmd_ready;
  assign fifoPop = startOp;
  assign fifoFlush = (stateQ == ST_READY) && !on;

  cmd_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) uFifo (
    .clk    (clk),
    .rst_n  (rst),
    .push   (fifoPush),
    .pop    (fifoPop),
    .flush  (fifoFlush),
    .wrData (fifoWr),
    .rdData (fifoRd),
    .full   (fifoFull),
    .empty  (fifoEmpty)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      stateQ <= ST_OFF;
    else
      stateQ <= stateD;
  end

  always_comb begin
    stateD = stateQ;
    unique case (stateQ)
      ST_OFF:
        if (on)
          stateD = ST_READY;
      ST_READY:
        if (!on)
          stateD = ST_OFF;
        else if (!fifoEmpty)
          stateD = ST_RUN;
      ST_RUN:
        if (cntQ == '0)
          stateD = (opQ == OP_MULT && dp_overflow)
                 ? ST_ERR : ST_READY;
      ST_ERR:
        if (err_ack)
          stateD = ST_READY;
      default:
        stateD = ST_OFF;
    endcase
  end

  // Selectors and operands only reach the datapath while running.
  always_comb begin
    cmd_ready = 1'b0;
    dp_in_sel = IN_RESET;
    dp_num1 = '0;
    dp_num2 = '0;
    res_error = 1'b0;
    unique case (stateQ)
      ST_OFF: ;
      ST_READY:
        cmd_ready = on && !fifoFull;
      ST_RUN: begin
        cmd_ready = on && !fifoFull;
        dp_in_sel = inSelQ;
        dp_num1 = num1Q;
        dp_num2 = num2Q;
      end
      ST_ERR: begin
        cmd_ready = on && !fifoFull;
        res_error = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      opQ <= OP_AND;
      cntQ <= '0;
      inSelQ <= IN_RESET;
      num1Q <= '0;
      num2Q <= '0;
      outSelQ <= OUT_AND;
      accQ <= '0;
      resDataQ <= '0;
      resValidQ <= 1'b0;
    end else begin
      resValidQ <= finishOp;
      if (startOp) begin
        opQ <= headOp;
        cntQ <= CNT_INIT;
        inSelQ <= opInSel(headOp);
        num1Q <= headLoad ? headA : accQ;
        num2Q <= headB;
        outSelQ <= opOutSel(headOp);
      end else if (stateQ == ST_RUN && cntQ != '0) begin
        cntQ <= cntQ - 1'b1;
      end
      // A faulted multiply leaves the chain value untouched.
      if (finishOp) begin
        resDataQ <= capture;
        if (!opFault)
          accQ <= capture;
      end
    end
  end

  assign dp_out_sel = outSelQ;
  assign res_valid = resValidQ;
  assign res_data = resDataQ;
  assign state = stateQ;
  assign next = stateD;

endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: datapath model plus scoreboard bench
// for the ALU command sequencer.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic on = 1'b0;
  logic cmd_valid = 1'b0;
  logic cmd_ready;
  logic [2:0] cmd_op = 3'd0;
  logic cmd_load = 1'b0;
  logic [7:0] cmd_a = 8'd0;
  logic [7:0] cmd_b = 8'd0;
  logic [2:0] dp_in_sel;
  logic [7:0] dp_num1;
  logic [7:0] dp_num2;
  logic [6:0] dp_out_sel;
  logic [7:0] dp_result;
  logic dp_overflow;
  logic res_valid;
  logic [7:0] res_data;
  logic res_error;
  logic err_ack = 1'b0;
  logic [1:0] state;
  logic [1:0] next;

  alu_sequencer #(
    .WIDTH (8),
    .DEPTH (4),
    .LAT   (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .on          (on),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_op      (cmd_op),
    .cmd_load    (cmd_load),
    .cmd_a       (cmd_a),
    .cmd_b       (cmd_b),
    .dp_in_sel   (dp_in_sel),
    .dp_num1     (dp_num1),
    .dp_num2     (dp_num2),
    .dp_out_sel  (dp_out_sel),
    .dp_result   (dp_result),
    .dp_overflow (dp_overflow),
    .res_valid   (res_valid),
    .res_data    (res_data),
    .res_error   (res_error),
    .err_ack     (err_ack),
    .state       (state),
    .next        (next)
  );

  always #5 clk = ~clk;

  // Datapath model: operand DFFs behind the input mux, then ALU.
  logic [7:0] r1;
  logic [7:0] r2;
  logic [15:0] prod;

  always @(posedge clk) begin
    if (dp_in_sel == 3'b100) begin
      r1 <= 8'd0;
      r2 <= 8'd0;
    end else if (dp_in_sel == 3'b010) begin
      r1 <= dp_num1;
      r2 <= dp_num2;
    end
  end

  always_comb begin
    prod = 16'(r1) * 16'(r2);
    dp_result = 8'd0;
    case (dp_out_sel)
      7'b0000001: dp_result = r1 & r2;
      7'b0000010: dp_result = r1 | r2;
      7'b0000100: dp_result = r1 ^ r2;
      7'b0001000: dp_result = ~r1;
      7'b0010000: dp_result = r1 + r2;
      7'b0100000: dp_result = r1 - r2;
      7'b1000000: dp_result = prod[7:0];
      default:    dp_result = 8'd0;
    endcase
    dp_overflow = dp_out_sel[6] && (prod[15:8] != 8'd0);
  end

  int nChecks = 0;
  int nPass = 0;
  int cyc = 0;
  int lastResCyc = -1;
  logic [7:0] sbq[$];
  int resCyc[$];
  logic [7:0] expD;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nChecks++;
    if (act === exp)
      nPass++;
    else
      $display("FAIL %s: got %0h want %0h (cycle %0d)",
               nm, act, exp, cyc);
  endtask

  always @(negedge clk) begin
    if (res_valid === 1'b1) begin
      resCyc.push_back(cyc);
      lastResCyc = cyc;
      if (sbq.size() == 0) begin
        chk("unexpected res_valid", 32'(res_valid), 32'd0);
      end else begin
        expD = sbq.pop_front();
        chk("res_data", 32'(res_data), 32'(expD));
      end
    end
  end

  // Called at posedge+1; returns with the accepting edge in tAcc.
  task automatic pushCmd(input logic [2:0] op, input logic ld,
                         input logic [7:0] a, input logic [7:0] b,
                         input bit want, input logic [7:0] exp,
                         output int tAcc);
    int n;
    n = 0;
    tAcc = -1;
    while (cmd_ready !== 1'b1 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 50) begin
      chk("cmd_ready timeout", 32'(cmd_ready), 32'd1);
      return;
    end
    cmd_valid = 1'b1;
    cmd_op = op;
    cmd_load = ld;
    cmd_a = a;
    cmd_b = b;
    if (want)
      sbq.push_back(exp);
    @(posedge clk);
    #1;
    tAcc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic waitResults();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 60) begin
      @(posedge clk);
      n++;
    end
    if (sbq.size() != 0) begin
      chk("result timeout", 32'(sbq.size()), 32'd0);
      sbq.delete();
    end
    #1;
  endtask

  task automatic chkReset(input string tag);
    chk({tag, " state"}, 32'(state), 32'd0);
    chk({tag, " cmd_ready"}, 32'(cmd_ready), 32'd0);
    chk({tag, " res_valid"}, 32'(res_valid), 32'd0);
    chk({tag, " res_data"}, 32'(res_data), 32'd0);
    chk({tag, " res_error"}, 32'(res_error), 32'd0);
    chk({tag, " dp_in_sel"}, 32'(dp_in_sel), 32'b100);
    chk({tag, " dp_num1"}, 32'(dp_num1), 32'd0);
    chk({tag, " dp_num2"}, 32'(dp_num2), 32'd0);
    chk({tag, " dp_out_sel"}, 32'(dp_out_sel), 32'b0000001);
  endtask

  typedef struct {
    logic [2:0] op;
    logic       ld;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin
    int t;
    int bad;

    #200000;
    $display("FAIL watchdog: bench did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int bad;

    // Chain starts from 0 after the CLR that precedes this table.
    tbl[0] = '{3'd0, 1'b1, 8'hF0, 8'h3C, 8'h30};
    tbl[1] = '{3'd1, 1'b1, 8'h0F, 8'h30, 8'h3F};
    tbl[2] = '{3'd2, 1'b0, 8'h00, 8'hFF, 8'hC0};
    tbl[3] = '{3'd3, 1'b0, 8'h00, 8'h00, 8'h3F};
    tbl[4] = '{3'd4, 1'b1, 8'hFF, 8'h02, 8'h01};
    tbl[5] = '{3'd5, 1'b1, 8'h00, 8'h01, 8'hFF};
    tbl[6] = '{3'd6, 1'b1, 8'h0F, 8'h11, 8'hFF};
    tbl[7] = '{3'd4, 1'b0, 8'h00, 8'h01, 8'h00};
    tbl[8] = '{3'd6, 1'b0, 8'h00, 8'hFF, 8'h00};
    tbl[9] = '{3'd4, 1'b1, 8'h40, 8'h02, 8'h42};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chkReset("reset");
    rst = 1'b1;
    on = 1'b1;
    @(posedge clk);
    #1;
    chk("off to ready", 32'(state), 32'd1);

    // Case 1: ADD with load, result latency.
    pushCmd(3'd4, 1'b1, 8'd5, 8'd3, 1'b1, 8'd8, t);
    @(posedge clk);
    @(negedge clk);
    chk("add run state", 32'(state), 32'd2);
    chk("add in_sel", 32'(dp_in_sel), 32'b010);
    chk("add out_sel", 32'(dp_out_sel), 32'b0010000);
    waitResults();
    chk("add latency", 32'(lastResCyc), 32'(t + 3));
    chk("add res_error", 32'(res_error), 32'd0);

    // Case 2: chained SUB, then CLR.
    pushCmd(3'd5, 1'b0, 8'hEE, 8'd2, 1'b1, 8'd6, t);
    @(posedge clk);
    @(negedge clk);
    chk("chain num1", 32'(dp_num1), 32'd8);
    chk("chain num2", 32'(dp_num2), 32'd2);
    waitResults();
    pushCmd(3'd7, 1'b1, 8'h77, 8'h11, 1'b1, 8'd0, t);
    @(posedge clk);
    @(negedge clk);
    chk("clr in_sel", 32'(dp_in_sel), 32'b100);
    chk("clr out_sel", 32'(dp_out_sel), 32'b0000001);
    waitResults();
    chk("idle state", 32'(state), 32'd1);
    chk("idle in_sel", 32'(dp_in_sel), 32'b100);
    chk("idle num1", 32'(dp_num1), 32'd0);

    for (int i = 0; i < 10; i++) begin
      pushCmd(tbl[i].op, tbl[i].ld, tbl[i].a, tbl[i].b,
              1'b1, tbl[i].exp, t);
      waitResults();
    end

    // Case 3/4: MULT overflow, then fill the FIFO while in error.
    pushCmd(3'd6, 1'b1, 8'h20, 8'h10, 1'b1, 8'h00, t);
    waitResults();
    chk("ovf state", 32'(state), 32'd3);
    chk("ovf res_error", 32'(res_error), 32'd1);
    pushCmd(3'd4, 1'b0, 8'h00, 8'h01, 1'b1, 8'h43, t);
    pushCmd(3'd5, 1'b0, 8'h00, 8'h03, 1'b1, 8'h40, t);
    pushCmd(3'd2, 1'b1, 8'hAA, 8'h55, 1'b1, 8'hFF, t);
    pushCmd(3'd0, 1'b0, 8'h00, 8'h0F, 1'b1, 8'h0F, t);
    chk("full cmd_ready", 32'(cmd_ready), 32'd0);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      if (state !== 2'b11)
        bad++;
    end
    chk("error hold cycles off", 32'(bad), 32'd0);
    resCyc.delete();
    err_ack = 1'b1;
    @(posedge clk);
    #1;
    err_ack = 1'b0;
    chk("err_ack to ready", 32'(state), 32'd1);
    waitResults();
    chk("burst count", 32'(resCyc.size()), 32'd4);
    for (int i = 1; i < resCyc.size(); i++)
      chk("burst spacing", 32'(resCyc[i] - resCyc[i-1]), 32'd3);

    // Case 5: on drops mid-RUN with work queued.
    pushCmd(3'd4, 1'b1, 8'h01, 8'h01, 1'b1, 8'h02, t);
    pushCmd(3'd1, 1'b1, 8'h11, 8'h22, 1'b0, 8'h00, t);
    pushCmd(3'd2, 1'b1, 8'h33, 8'h44, 1'b0, 8'h00, t);
    chk("drop-on in run", 32'(state), 32'd2);
    on = 1'b0;
    @(negedge clk);
    chk("off cmd_ready", 32'(cmd_ready), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    chk("powered down", 32'(state), 32'd0);
    chk("last op done", 32'(sbq.size()), 32'd0);
    on = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("flushed stays ready", 32'(state), 32'd1);

    // Case 6: reset in the second RUN cycle.
    pushCmd(3'd4, 1'b1, 8'h01, 8'h01, 1'b1, 8'h02, t);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("pre-reset state", 32'(state), 32'd2);
    rst = 1'b0;
    #1;
    chkReset("mid-run reset");
    sbq.delete();
    on = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("post-reset state", 32'(state), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("post-reset idle", 32'(state), 32'd0);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
